orb_brief_sampler: RTL and testbench

- Initiator that drives the random-access read side of the ORB patch window and produces one binary BRIEF descriptor per keypoint.
- Sits between the keypoint detector and the descriptor output FIFO.
- On a keypoint request against a valid patch it:
  - switches the window to read mode and stalls column input;
  - streams NUM_PAIRS coordinate pairs from a pattern ROM;
  - compares the returned pixel pairs into descriptor bits;
  - returns the window to write mode and presents the descriptor with a valid/ready handshake.

---
 rtl/orb_pkg.sv | 44 ++++
 rtl/orb_brief_sampler_pattern_rom.sv | 29 ++
 rtl/orb_brief_sampler.sv | 155 +++++++++++++++
 tb/tb_orb_brief_sampler.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/orb_pkg.sv
// Shared types for the ORB BRIEF sampler: FSM state, sample coordinates and
// the built-in sampling pattern that fills the pattern ROM.
package orb_pkg;

  localparam int NUM_PAIRS_DEFAULT      = 256;
  localparam int SAMPLE_LATENCY_DEFAULT = 1;
  localparam int COORD_BITS_DEFAULT     = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    DRAIN  = 2'd2,
    OUTPUT = 2'd3
  } sampler_state_t;

  typedef logic signed [COORD_BITS_DEFAULT-1:0] coord_t;

  typedef struct packed {
    coord_t x1;
    coord_t y1;
    coord_t x2;
    coord_t y2;
  } pattern_t;

  // Folds any integer into the +/-15 patch radius.
  function automatic coord_t fold_coord(input int v);
    int r;
    r = v % 31;
    if (r < 0) r = r + 31;
    if (r > 15) r = r - 31;
    return coord_t'(r);
  endfunction

  // Deterministic pattern; pair 0 compares (1,0) against (-1,0).
  function automatic pattern_t pattern_entry(input int idx);
    pattern_t e;
    e.x1 = fold_coord(idx * 5 + 1);
    e.y1 = fold_coord(idx * 3);
    e.x2 = fold_coord(-(idx * 7 + 1));
    e.y2 = fold_coord(idx * 13);
    return e;
  endfunction

endpackage

// File: rtl/orb_brief_sampler_pattern_rom.sv
// Synchronous 1-clock pattern ROM holding NUM_PAIRS coordinate pairs.
// Contents are generated from the package pattern, so no init block is needed.
module orb_pattern_rom
  import orb_pkg::*;
#(
  parameter int NUM_PAIRS    = NUM_PAIRS_DEFAULT,
  parameter     PATTERN_FILE = "orb_pattern.mif",
  localparam int AW          = $clog2(NUM_PAIRS)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  output pattern_t      q
);

  pattern_t rom_table [NUM_PAIRS];

  // The file name only tags which table the generator reproduces.
  logic [$bits(PATTERN_FILE)-1:0] unused_pattern_name;
  assign unused_pattern_name = PATTERN_FILE;

  for (genvar i = 0; i < NUM_PAIRS; i++) begin : g_rom
    assign rom_table[i] = pattern_entry(i);
  end

  always_ff @(posedge clk) begin
    q <= rom_table[addr];
  end

endmodule

// File: rtl/orb_brief_sampler.sv
// BRIEF descriptor initiator: reads NUM_PAIRS pixel pairs from the patch window
// and presents the comparison bits. Optional: ORB_SAMPLER_MOMENT_LATCH_EN.
//
// Handshakes: a transfer happens on a clock edge where valid && ready are both
// high; valid never depends on ready, and out_desc is held while valid && !ready.
module orb_brief_sampler
  import orb_pkg::*;
#(
  parameter int LUMA_BITS      = 8,
  parameter int COORD_BITS     = COORD_BITS_DEFAULT,
  parameter int MOMENT_BITS    = 24,
  parameter int NUM_PAIRS      = NUM_PAIRS_DEFAULT,
  parameter int SAMPLE_LATENCY = SAMPLE_LATENCY_DEFAULT,
  parameter     PATTERN_FILE   = "orb_pattern.mif"
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_kp_valid,
  output logic                    out_kp_ready,
  input  logic                    in_patch_valid,
  input  logic [MOMENT_BITS-1:0]  in_xmoment,
  input  logic [MOMENT_BITS-1:0]  in_ymoment,
  output logic                    out_mode,
  output logic                    out_flush,
  output logic [2*COORD_BITS-1:0] out_coord1,
  output logic [2*COORD_BITS-1:0] out_coord2,
  input  logic [LUMA_BITS-1:0]    in_pix1,
  input  logic [LUMA_BITS-1:0]    in_pix2,
  output logic                    out_col_stall,
  input  logic                    in_abort,
  output logic                    out_desc_valid,
  input  logic                    in_desc_ready,
  output logic [NUM_PAIRS-1:0]    out_desc,
`ifdef ORB_SAMPLER_MOMENT_LATCH_EN
  output logic [MOMENT_BITS-1:0]  out_desc_xmoment,
  output logic [MOMENT_BITS-1:0]  out_desc_ymoment,
`endif
  output sampler_state_t          dbg_state
);

  localparam int            CW        = $clog2(NUM_PAIRS);
  localparam logic [CW-1:0] LAST_PAIR = CW'(NUM_PAIRS - 1);

  sampler_state_t           state_q, state_d;
  logic [CW-1:0]            cnt_q;
  logic                     coord_vld_q, coord_last_q;
  logic [SAMPLE_LATENCY-1:0] pix_vld_q, pix_last_q;
  logic [NUM_PAIRS-1:0]     desc_q;
  logic                     flush_q;
  pattern_t                 rom_q;

  logic accept, handshake, abort_act, issue, issue_last;
  logic capture, capture_last, reading;

  orb_pattern_rom #(
    .NUM_PAIRS    (NUM_PAIRS),
    .PATTERN_FILE (PATTERN_FILE)
  ) u_rom (
    .clk  (clk),
    .addr (cnt_q),
    .q    (rom_q)
  );

  assign out_kp_ready = (state_q == IDLE) && in_patch_valid && !in_abort;
  assign accept       = in_kp_valid && out_kp_ready;
  assign handshake    = (state_q == OUTPUT) && in_desc_ready;
  // A completing handshake wins over a same-cycle abort.
  assign abort_act    = in_abort && (state_q != IDLE) && !handshake;
  assign issue        = (state_q == SAMPLE) && !in_abort;
  assign issue_last   = issue && (cnt_q == LAST_PAIR);
  assign capture      = pix_vld_q[SAMPLE_LATENCY-1];
  assign capture_last = capture && pix_last_q[SAMPLE_LATENCY-1];
  assign reading      = (state_q == SAMPLE) || (state_q == DRAIN);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)       state_d = SAMPLE;
      SAMPLE:  if (issue_last)   state_d = DRAIN;
      DRAIN:   if (capture_last) state_d = OUTPUT;
      OUTPUT:  if (in_desc_ready) state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
    if (abort_act) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      coord_vld_q  <= 1'b0;
      coord_last_q <= 1'b0;
      flush_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      coord_vld_q  <= issue;
      coord_last_q <= issue_last;
      flush_q      <= abort_act;
      if (abort_act || issue_last) cnt_q <= '0;
      else if (issue)              cnt_q <= cnt_q + 1'b1;
    end
  end

  // Pixel-return alignment: valid/last follow the coordinates by the window latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_vld_q  <= '0;
      pix_last_q <= '0;
    end else if (abort_act) begin
      pix_vld_q  <= '0;
      pix_last_q <= '0;
    end else begin
      pix_vld_q[0]  <= coord_vld_q;
      pix_last_q[0] <= coord_last_q;
      for (int i = 1; i < SAMPLE_LATENCY; i++) begin
        pix_vld_q[i]  <= pix_vld_q[i-1];
        pix_last_q[i] <= pix_last_q[i-1];
      end
    end
  end

  // Right shift so pair 0, shifted in first, lands in bit 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      desc_q <= '0;
    end else if (capture && !abort_act) begin
      desc_q <= {(in_pix1 < in_pix2), desc_q[NUM_PAIRS-1:1]};
    end
  end

`ifdef ORB_SAMPLER_MOMENT_LATCH_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_desc_xmoment <= '0;
      out_desc_ymoment <= '0;
    end else if (accept) begin
      out_desc_xmoment <= in_xmoment;
      out_desc_ymoment <= in_ymoment;
    end
  end
`else
  logic unused_moments;
  assign unused_moments = ^{in_xmoment, in_ymoment};
`endif

  assign out_mode       = !reading;
  assign out_col_stall  = reading || accept;
  assign out_flush      = flush_q;
  assign out_desc_valid = (state_q == OUTPUT);
  assign out_desc       = desc_q;
  assign out_coord1     = coord_vld_q ? {COORD_BITS'(rom_q.x1), COORD_BITS'(rom_q.y1)} : '0;
  assign out_coord2     = coord_vld_q ? {COORD_BITS'(rom_q.x2), COORD_BITS'(rom_q.y2)} : '0;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_orb_brief_sampler.sv
// Self-checking bench for orb_brief_sampler with NUM_PAIRS=8 and a 1-clock
// window model; table-driven descriptors plus abort and reset sequences.
module tb_orb_brief_sampler;
  import orb_pkg::*;

  localparam int NP = 8;
  localparam int SL = 1;
  localparam int MB = 24;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_kp_valid, in_patch_valid, in_abort, in_desc_ready;
  logic [MB-1:0] in_xmoment, in_ymoment;
  logic [7:0]    in_pix1, in_pix2;
  logic          out_kp_ready, out_mode, out_flush, out_col_stall, out_desc_valid;
  logic [11:0]   out_coord1, out_coord2;
  logic [NP-1:0] out_desc;
  sampler_state_t dbg_state;
`ifdef ORB_SAMPLER_MOMENT_LATCH_EN
  logic [MB-1:0] out_desc_xmoment, out_desc_ymoment;
  logic [MB-1:0] mom_q[$];
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int win_mode = 0;
  logic [NP-1:0] exp_q[$];

  typedef struct {
    int            mode;
    int            pre_wait;
    int            hold;
    bit            abort_hs;
    logic [NP-1:0] exp_desc;
  } vec_t;
  vec_t vecs[4];

  orb_brief_sampler #(
    .LUMA_BITS(8), .COORD_BITS(6), .MOMENT_BITS(MB),
    .NUM_PAIRS(NP), .SAMPLE_LATENCY(SL)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .in_kp_valid(in_kp_valid), .out_kp_ready(out_kp_ready),
    .in_patch_valid(in_patch_valid),
    .in_xmoment(in_xmoment), .in_ymoment(in_ymoment),
    .out_mode(out_mode), .out_flush(out_flush),
    .out_coord1(out_coord1), .out_coord2(out_coord2),
    .in_pix1(in_pix1), .in_pix2(in_pix2),
    .out_col_stall(out_col_stall), .in_abort(in_abort),
    .out_desc_valid(out_desc_valid), .in_desc_ready(in_desc_ready),
    .out_desc(out_desc),
`ifdef ORB_SAMPLER_MOMENT_LATCH_EN
    .out_desc_xmoment(out_desc_xmoment), .out_desc_ymoment(out_desc_ymoment),
`endif
    .dbg_state(dbg_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Window image and 1-clock read-latency window model
  function automatic logic [7:0] img(input int x, input int y);
    if (x == 1 && y == 0)  return 8'd10;
    if (x == -1 && y == 0) return 8'd20;
    return 8'((x + 16) * 9 + (y + 16) * 23 + 3);
  endfunction

  function automatic logic [7:0] pix_at(input logic [11:0] c, input int mode);
    logic signed [5:0] cx, cy;
    cx = c[11:6];
    cy = c[5:0];
    if (mode == 1) return 8'd128;
    return img(int'(cx), int'(cy));
  endfunction

  always @(posedge clk) begin
    if (win_mode == 2) begin
      in_pix1 <= 8'd0;
      in_pix2 <= 8'd255;
    end else begin
      in_pix1 <= pix_at(out_coord1, win_mode);
      in_pix2 <= pix_at(out_coord2, win_mode);
    end
  end

  function automatic logic [NP-1:0] image_desc();
    logic [NP-1:0] r;
    pattern_t e;
    for (int k = 0; k < NP; k++) begin
      e = pattern_entry(k);
      r[k] = img(int'(e.x1), int'(e.y1)) < img(int'(e.x2), int'(e.y2));
    end
    return r;
  endfunction

  // Driver / checker tasks
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_desc(input vec_t v);
    logic [15:0]   mode_tr, stall_tr, valid_tr, exp_mode, exp_stall, exp_valid;
    logic [NP-1:0] held, exp_d;
    int bad;
    win_mode = v.mode;
    in_kp_valid = 1'b1;
    in_patch_valid = 1'b0;
    bad = 0;
    for (int w = 0; w < v.pre_wait; w++) begin
      #1;
      if (out_kp_ready !== 1'b0 || dbg_state !== IDLE) bad++;
      tick();
    end
    if (v.pre_wait > 0) check("wait_patch_invalid", 64'(bad), 64'd0);
    in_patch_valid = 1'b1;
    in_xmoment = MB'($urandom_range(0, 32'hFFFFFF));
    in_ymoment = MB'($urandom_range(0, 32'hFFFFFF));
    #1;
    check("kp_ready_on_request", 64'(out_kp_ready), 64'd1);
    exp_q.push_back(v.exp_desc);
`ifdef ORB_SAMPLER_MOMENT_LATCH_EN
    mom_q.push_back(in_xmoment);
`endif
    mode_tr = '0; stall_tr = '0; valid_tr = '0;
    exp_mode = '0; exp_stall = '0; exp_valid = '0;
    mode_tr[0] = out_mode; stall_tr[0] = out_col_stall; valid_tr[0] = out_desc_valid;
    for (int c = 0; c <= NP + 2 + SL; c++) begin
      exp_mode[c]  = !(c >= 1 && c <= NP + 1 + SL);
      exp_stall[c] = (c <= NP + 1 + SL);
      exp_valid[c] = (c == NP + 2 + SL);
    end
    for (int c = 1; c <= NP + 2 + SL; c++) begin
      tick();
      if (c == 1) in_kp_valid = 1'b0;
      #1;
      mode_tr[c] = out_mode; stall_tr[c] = out_col_stall; valid_tr[c] = out_desc_valid;
      if (c == 1) check("coord_zero_before_pair0", 64'(out_coord1), 64'd0);
      if (c == 2) begin
        check("coord1_pair0", 64'(out_coord1), 64'h040);
        check("coord2_pair0", 64'(out_coord2), 64'hFC0);
      end
    end
    check("mode_trace", 64'(mode_tr), 64'(exp_mode));
    check("stall_trace", 64'(stall_tr), 64'(exp_stall));
    check("valid_trace", 64'(valid_tr), 64'(exp_valid));
    held = out_desc;
    in_kp_valid = 1'b1;
    bad = 0;
    for (int h = 0; h < v.hold; h++) begin
      tick();
      #1;
      if (out_desc !== held || out_desc_valid !== 1'b1 || out_kp_ready !== 1'b0) bad++;
    end
    if (v.hold > 0) check("hold_stable_no_accept", 64'(bad), 64'd0);
    in_kp_valid = 1'b0;
    in_desc_ready = 1'b1;
    in_abort = v.abort_hs;
    #1;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      exp_d = exp_q.pop_front();
      check("desc", 64'(out_desc), 64'(exp_d));
    end
`ifdef ORB_SAMPLER_MOMENT_LATCH_EN
    if (mom_q.size() > 0) check("desc_xmoment", 64'(out_desc_xmoment), 64'(mom_q.pop_front()));
`endif
    tick();
    in_desc_ready = 1'b0;
    in_abort = 1'b0;
    #1;
    check("idle_after_handshake", 64'(dbg_state), 64'(IDLE));
    check("valid_low_after_handshake", 64'(out_desc_valid), 64'd0);
    check("no_flush_after_handshake", 64'(out_flush), 64'd0);
  endtask

  // Main test
  initial begin
    int bad;
    vecs[0] = '{mode: 0, pre_wait: 0, hold: 0,  abort_hs: 1'b0, exp_desc: image_desc()};
    vecs[1] = '{mode: 1, pre_wait: 0, hold: 3,  abort_hs: 1'b0, exp_desc: 8'h00};
    vecs[2] = '{mode: 2, pre_wait: 5, hold: 20, abort_hs: 1'b0, exp_desc: 8'hFF};
    vecs[3] = '{mode: 0, pre_wait: 0, hold: 2,  abort_hs: 1'b1, exp_desc: image_desc()};

    in_kp_valid = 0; in_patch_valid = 0; in_abort = 0; in_desc_ready = 0;
    in_xmoment = '0; in_ymoment = '0;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    check("rst_mode", 64'(out_mode), 64'd1);
    check("rst_flush", 64'(out_flush), 64'd0);
    check("rst_stall", 64'(out_col_stall), 64'd0);
    check("rst_valid", 64'(out_desc_valid), 64'd0);
    check("rst_desc", 64'(out_desc), 64'd0);
    check("rst_coords", 64'({out_coord1, out_coord2}), 64'd0);
    tick(); tick();
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) begin
      run_desc(vecs[i]);
      tick();
    end

    // Abort: rejected in IDLE, then mid-SAMPLE at T+4
    win_mode = 0;
    in_kp_valid = 1'b1; in_patch_valid = 1'b1; in_abort = 1'b1;
    #1;
    check("abort_idle_blocks_ready", 64'(out_kp_ready), 64'd0);
    tick();
    in_abort = 1'b0;
    #1;
    check("abort_idle_no_effect", 64'(dbg_state), 64'(IDLE));
    check("ready_after_idle_abort", 64'(out_kp_ready), 64'd1);
    bad = 0;
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (c == 1) in_kp_valid = 1'b0;
      in_abort = (c == 4);
      #1;
      if (out_desc_valid) bad++;
      if (c == 4) check("abort_mode_before", 64'(out_mode), 64'd0);
      if (c == 5) begin
        check("abort_mode_after", 64'(out_mode), 64'd1);
        check("abort_flush_pulse", 64'(out_flush), 64'd1);
        check("abort_state_idle", 64'(dbg_state), 64'(IDLE));
      end
      if (c == 6) check("abort_flush_one_cycle", 64'(out_flush), 64'd0);
    end
    check("abort_no_desc_valid", 64'(bad), 64'd0);
    in_abort = 1'b0;
    run_desc(vecs[0]);
    tick();

    // Asynchronous reset mid-SAMPLE at T+6
    in_kp_valid = 1'b1; in_patch_valid = 1'b1;
    #1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 1) in_kp_valid = 1'b0;
    end
    #1;
    check("mid_sample_mode", 64'(out_mode), 64'd0);
    reset_n = 1'b0;
    #1;
    check("arst_mode", 64'(out_mode), 64'd1);
    check("arst_stall", 64'(out_col_stall), 64'd0);
    check("arst_state", 64'(dbg_state), 64'(IDLE));
    check("arst_coords", 64'({out_coord1, out_coord2}), 64'd0);
    check("arst_desc", 64'(out_desc), 64'd0);
    check("arst_valid_flush", 64'({out_desc_valid, out_flush}), 64'd0);
    tick();
    reset_n = 1'b1;
    tick();
    run_desc(vecs[1]);
    tick();

    if (exp_q.size() != 0) check("scoreboard_leftover", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
